pipelined_reduce_tree: RTL and testbench

//  N-channel registered reduction engine, DW bits per channel. Captures all channels on an

---
 rtl/pipelined_reduce_tree_pkg.sv | 34 +++
 rtl/pipelined_reduce_tree_level.sv | 60 ++++++
 rtl/pipelined_reduce_tree.sv | 99 +++++++++
 tb/tb_pipelined_reduce_tree.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_reduce_tree_pkg.sv
// Shared op encoding and the two-input combine used by every node of the reduction tree.
package reduce_pkg;

  typedef enum logic [2:0] {
    OP_SUM = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_XOR = 3'd3,
    OP_MAX = 3'd4,
    OP_MIN = 3'd5
  } op_e;

  // Wide enough for any legal node (DW up to 32 plus five tree levels).
  localparam int NODE_W = 64;
  typedef logic [NODE_W-1:0] node_t;

  // Operands arrive zero-extended, so logic/MAX/MIN results keep their top bits zero.
  // The op stays a raw 3-bit field so the reserved encodings 6 and 7 fall through to zero.
  function automatic node_t reduce2(logic [2:0] op, node_t a, node_t b);
    node_t r;
    r = '0;
    case (op)
      OP_SUM:  r = a + b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MAX:  r = (a > b) ? a : b;
      OP_MIN:  r = (a < b) ? a : b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipelined_reduce_tree_level.sv
// One registered level of the reduction tree: pairs adjacent nodes and widens each result by one bit.
module reduce_level
  import reduce_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int IW   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [2:0]                 in_op,
  input  logic [N_IN*IW-1:0]         in_data,
  output logic                       out_valid,
  output logic [2:0]                 out_op,
  output logic [(N_IN/2)*(IW+1)-1:0] out_data
);

  localparam int N_OUT = N_IN / 2;
  localparam int NW    = IW + 1;

  logic                valid_d, valid_q;
  logic [2:0]          op_d, op_q;
  logic [N_OUT*NW-1:0] data_d, data_q;

  always_comb begin
    // NOTE: every comb output takes its held value first, so no path can infer a latch.
    valid_d = valid_q;
    op_d    = op_q;
    data_d  = data_q;
    if (en) begin
      valid_d = in_valid;
      op_d    = in_op;
      for (int i = 0; i < N_OUT; i++) begin
        data_d[i*NW +: NW] = NW'(reduce2(in_op,
                                         node_t'(in_data[(2*i)*IW +: IW]),
                                         node_t'(in_data[(2*i+1)*IW +: IW])));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data and op registers are reset as well as valid, so out_data and out_op read 0 after reset.
      valid_q <= 1'b0;
      op_q    <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: state updates are non-blocking so every level samples its predecessor's old value.
      valid_q <= valid_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_op    = op_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pipelined_reduce_tree.sv
// N-channel registered reduction engine: input register S0 followed by log2(N_CH) tree levels,
// all advancing together on a single global enable so a downstream stall freezes the pipeline.
module pipelined_reduce_tree
  import reduce_pkg::*;
#(
  parameter int  N_CH = 4,
  parameter int  DW   = 8,
  localparam int OW   = DW + $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [2:0]         in_op,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OW-1:0]      out_data,
  output logic [2:0]         out_op,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int L = $clog2(N_CH);

  logic               adv;
  logic               accept;
  logic               s0_valid_d, s0_valid_q;
  logic [2:0]         s0_op_d, s0_op_q;
  logic [N_CH*DW-1:0] s0_data_d, s0_data_q;

  // Bubbles are not squeezed out: the whole pipe moves or holds as one.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_op_d    = s0_op_q;
    s0_data_d  = s0_data_q;
    if (adv) begin
      s0_valid_d = accept;
      s0_op_d    = in_op;
      s0_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_op_q    <= '0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_op_q    <= s0_op_d;
      s0_data_q  <= s0_data_d;
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int IW   = DW + k;
    localparam int N_IN = N_CH >> k;

    logic                       v_in;
    logic [2:0]                 op_in;
    logic [N_IN*IW-1:0]         d_in;
    logic                       v_out;
    logic [2:0]                 op_out;
    logic [(N_IN/2)*(IW+1)-1:0] d_out;

    if (k == 0) begin : g_first
      assign v_in  = s0_valid_q;
      assign op_in = s0_op_q;
      assign d_in  = s0_data_q;
    end else begin : g_rest
      assign v_in  = g_lvl[k-1].v_out;
      assign op_in = g_lvl[k-1].op_out;
      assign d_in  = g_lvl[k-1].d_out;
    end

    reduce_level #(
      .N_IN (N_IN),
      .IW   (IW)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (v_in),
      .in_op     (op_in),
      .in_data   (d_in),
      .out_valid (v_out),
      .out_op    (op_out),
      .out_data  (d_out)
    );
  end

  assign out_valid = g_lvl[L-1].v_out;
  assign out_op    = g_lvl[L-1].op_out;
  assign out_data  = g_lvl[L-1].d_out;

endmodule

// File: tb/tb_pipelined_reduce_tree.sv
// Scoreboard bench: drivers push the expected result on every accepted beat, per-instance
// monitors pop and compare whenever a result is taken. Instance A is 4x8, instance B is 8x4.
module tb_pipelined_reduce_tree;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  op;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] a_in_data = '0;
  logic [2:0]  a_in_op = '0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [9:0]  a_out_data;
  logic [2:0]  a_out_op;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [15:0] a_exp = '0;

  logic [31:0] b_in_data = '0;
  logic [2:0]  b_in_op = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [6:0]  b_out_data;
  logic [2:0]  b_out_op;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [15:0] b_exp = '0;

  exp_t a_q[$];
  exp_t b_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic lat_a = 1'b0;
  logic lat_b = 1'b0;

  pipelined_reduce_tree #(.N_CH(4), .DW(8)) u_a (
    .clk       (clk),
    .rst       (rst),
    .in_data   (a_in_data),
    .in_op     (a_in_op),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_op    (a_out_op),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  pipelined_reduce_tree #(.N_CH(8), .DW(4)) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_data   (b_in_data),
    .in_op     (b_in_op),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_op    (b_out_op),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sequential fold over channels; independent of the DUT's pairwise tree.
  function automatic logic [15:0] model(input int n, input int dw, input logic [31:0] d,
                                        input logic [2:0] op);
    logic [31:0] mask;
    logic [15:0] acc;
    logic [15:0] v;
    mask = (32'd1 << dw) - 32'd1;
    acc  = 16'(d & mask);
    for (int c = 1; c < n; c++) begin
      v = 16'((d >> (c * dw)) & mask);
      case (op)
        3'd0:    acc = acc + v;
        3'd1:    acc = acc & v;
        3'd2:    acc = acc | v;
        3'd3:    acc = acc ^ v;
        3'd4:    if (v > acc) acc = v;
        3'd5:    if (v < acc) acc = v;
        default: acc = '0;
      endcase
    end
    return acc;
  endfunction

  // Input-side scoreboard feeders.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      a_q.delete();
      b_q.delete();
    end else begin
      if (a_in_valid && a_in_ready) a_q.push_back('{a_exp, a_in_op, cyc});
      if (b_in_valid && b_in_ready) b_q.push_back('{b_exp, b_in_op, cyc});
    end
  end

  initial begin : mon_a
    exp_t e;
    logic pstall;
    logic [9:0] pd;
    logic [2:0] po;
    pstall = 1'b0;
    pd = '0;
    po = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pstall = 1'b0;
      end else begin
        if (pstall) begin
          check("a_hold_data", 32'(a_out_data), 32'(pd));
          check("a_hold_op", 32'(a_out_op), 32'(po));
          check("a_hold_valid", 32'(a_out_valid), 32'd1);
        end
        if (a_out_valid && !a_out_ready) check("a_stall_in_ready", 32'(a_in_ready), 32'd0);
        if (a_out_valid && a_out_ready) begin
          if (a_q.size() == 0) begin
            check("a_spurious_out", 32'(a_out_valid), 32'd0);
          end else begin
            e = a_q.pop_front();
            check("a_data", 32'(a_out_data), 32'(e.data));
            check("a_op", 32'(a_out_op), 32'(e.op));
            if (lat_a) check("a_latency", 32'(cyc - e.cyc), 32'd3);
          end
        end
        pstall = a_out_valid && !a_out_ready;
        pd = a_out_data;
        po = a_out_op;
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    logic pstall;
    logic [6:0] pd;
    logic [2:0] po;
    pstall = 1'b0;
    pd = '0;
    po = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pstall = 1'b0;
      end else begin
        if (pstall) begin
          check("b_hold_data", 32'(b_out_data), 32'(pd));
          check("b_hold_op", 32'(b_out_op), 32'(po));
          check("b_hold_valid", 32'(b_out_valid), 32'd1);
        end
        if (b_out_valid && !b_out_ready) check("b_stall_in_ready", 32'(b_in_ready), 32'd0);
        if (b_out_valid && b_out_ready) begin
          if (b_q.size() == 0) begin
            check("b_spurious_out", 32'(b_out_valid), 32'd0);
          end else begin
            e = b_q.pop_front();
            check("b_data", 32'(b_out_data), 32'(e.data));
            check("b_op", 32'(b_out_op), 32'(e.op));
            if (lat_b) check("b_latency", 32'(cyc - e.cyc), 32'd4);
          end
        end
        pstall = b_out_valid && !b_out_ready;
        pd = b_out_data;
        po = b_out_op;
      end
    end
  end

  // Drivers start just after a rising edge and return just after the accepting edge.
  task automatic a_send(input logic [31:0] d, input logic [2:0] op, input logic [15:0] e);
    int w;
    a_in_data  = d;
    a_in_op    = op;
    a_exp      = e;
    a_in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!a_in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (w >= 100) check("a_accept_timeout", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic b_send(input logic [31:0] d, input logic [2:0] op, input logic [15:0] e);
    int w;
    b_in_data  = d;
    b_in_op    = op;
    b_exp      = e;
    b_in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!b_in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (w >= 100) check("b_accept_timeout", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((a_q.size() != 0 || b_q.size() != 0) && w < 200) begin
      @(posedge clk);
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_pending", 32'(a_q.size() + b_q.size()), 32'd0);
  endtask

  initial begin : stim
    int   acc_cnt;
    int   guard;
    logic acc;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_out_data", 32'(a_out_data), 32'd0);
    check("rst_a_out_op", 32'(a_out_op), 32'd0);
    check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_out_data", 32'(b_out_data), 32'd0);
    @(posedge clk);
    #1;

    // SUM plus reserved ops, full throughput with latency checking.
    lat_a = 1'b1;
    a_send(32'hFFFF_FFFF, 3'd0, 16'h03FC);
    a_send(32'h0403_0201, 3'd0, 16'h000A);
    a_send(32'hFFFF_FFFF, 3'd6, 16'h0000);
    a_send(32'h1234_5678, 3'd7, 16'h0000);
    // Op mix on one vector, back to back.
    a_send(32'hF8FF_3CF0, 3'd1, 16'h0030);
    a_send(32'hF8FF_3CF0, 3'd2, 16'h00FF);
    a_send(32'hF8FF_3CF0, 3'd3, 16'h00CB);
    a_send(32'hF8FF_3CF0, 3'd4, 16'h00FF);
    a_send(32'hF8FF_3CF0, 3'd5, 16'h003C);
    drain();

    // Six-beat stream with out_ready dropped for four cycles mid-stream.
    lat_a = 1'b0;
    fork
      begin
        a_send(32'h0403_0201, 3'd0, 16'h000A);
        a_send(32'h8080_8080, 3'd0, 16'h0200);
        a_send(32'h0F0F_0F0F, 3'd1, 16'h000F);
        a_send(32'h0102_0408, 3'd2, 16'h000F);
        a_send(32'h1234_5678, 3'd4, 16'h0078);
        a_send(32'h1234_5678, 3'd5, 16'h0012);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a_out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: neither may emerge; the next beat sees normal latency.
    lat_a = 1'b1;
    a_send(32'h0101_0101, 3'd0, 16'h0004);
    a_send(32'h0202_0202, 3'd0, 16'h0008);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("flush_a_out_valid", 32'(a_out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    a_send(32'h1111_1111, 3'd0, 16'h0044);
    drain();
    lat_a = 1'b0;

    // 8x4 instance: all-ones SUM with four-cycle latency.
    lat_b = 1'b1;
    b_send(32'hFFFF_FFFF, 3'd0, 16'h0078);
    drain();
    lat_b = 1'b0;

    // 8x4 instance: 1000 random beats with random valid and ready.
    acc_cnt = 0;
    guard = 0;
    while (acc_cnt < 1000 && guard < 20000) begin
      @(negedge clk);
      acc = b_in_valid && b_in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) acc_cnt++;
      if (acc || !b_in_valid) begin
        b_in_valid = ($urandom_range(3) != 0);
        b_in_data  = $urandom;
        b_in_op    = 3'($urandom_range(7));
        b_exp      = model(8, 4, b_in_data, b_in_op);
      end
      b_out_ready = ($urandom_range(3) != 0);
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    check("b_random_beats", 32'(acc_cnt), 32'd1000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
